// File: rtl/edge_event_monitor.sv
// edge_event_monitor: multi-channel edge classifier with event pulses, sticky flags and saturating counters
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   sig_in        - WIDTH monitored (pre-synchronised) signals
//   mode          - 2 bits per channel: 00 rise, 01 fall, 10 any change, 11 disabled
//   en            - event enable (history keeps tracking while low)
//   clr           - synchronous clear of sticky flags and counters
//   cnt_sel       - counter readback select
//   evt           - registered one-cycle event pulse per channel
//   sticky        - per-channel flag set on event, held until clr
//   any_evt       - registered OR of all channel events
//   cnt_out       - counter[cnt_sel], zero when cnt_sel is out of range
//   cnt_sat       - per-channel counter-at-all-ones flag
module edge_event_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter bit FIRST_SAMPLE_EDGE = 1'b1,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sig_in,
    input  logic [2*WIDTH-1:0] mode,
    input  logic               en,
    input  logic               clr,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [WIDTH-1:0]   evt,
    output logic [WIDTH-1:0]   sticky,
    output logic               any_evt,
    output logic [CNT_W-1:0]   cnt_out,
    output logic [WIDTH-1:0]   cnt_sat
);
    logic [WIDTH-1:0] past, prev, rise, fall, hit;
    logic             past_valid;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Unknown history is modelled as the complement of the sample (X->s always
    // a transition) or as the sample itself (no transition).
    assign prev = past_valid ? past : (FIRST_SAMPLE_EDGE ? ~sig_in : sig_in);
    assign rise = sig_in & ~prev;
    assign fall = ~sig_in & prev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign hit[i] = en & (mode[2*i+1] ? (~mode[2*i] & (rise[i] | fall[i]))
                                          : (mode[2*i] ? fall[i] : rise[i]));
        assign cnt_sat[i] = &cnt[i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt[i] <= '0;
            else if (clr)
                cnt[i] <= '0;
            else if (hit[i] && !cnt_sat[i])
                cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            past       <= '0;
            past_valid <= 1'b0;
            evt        <= '0;
            any_evt    <= 1'b0;
            sticky     <= '0;
        end else begin
            past       <= sig_in;
            past_valid <= 1'b1;
            evt        <= hit;
            any_evt    <= |hit;
            sticky     <= clr ? '0 : (sticky | hit);
        end
    end

    assign cnt_out = (32'(cnt_sel) < WIDTH) ? cnt[cnt_sel] : '0;
endmodule

// File: tb/tb_edge_event_monitor.sv
// tb_edge_event_monitor: directed plus randomized checks of two edge_event_monitor configurations
module tb_edge_event_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  sig = '0;
    logic [15:0] mode = '0;
    logic [2:0]  sel = '0;

    logic [7:0] evt_a, sticky_a, sat_a;
    logic       any_a;
    logic [1:0] cnt_a;
    logic [5:0] evt_b, sticky_b, sat_b;
    logic       any_b;
    logic [7:0] cnt_b;

    edge_event_monitor #(.WIDTH(8), .CNT_W(2), .FIRST_SAMPLE_EDGE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig), .mode(mode), .en(en), .clr(clr),
        .cnt_sel(sel), .evt(evt_a), .sticky(sticky_a), .any_evt(any_a),
        .cnt_out(cnt_a), .cnt_sat(sat_a)
    );

    edge_event_monitor #(.WIDTH(6), .CNT_W(8), .FIRST_SAMPLE_EDGE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig[5:0]), .mode(mode[11:0]), .en(en), .clr(clr),
        .cnt_sel(sel), .evt(evt_b), .sticky(sticky_b), .any_evt(any_b),
        .cnt_out(cnt_b), .cnt_sat(sat_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;

    int w[2]    = '{8, 6};
    int cmax[2] = '{3, 255};
    bit fse[2]  = '{1'b1, 1'b0};
    int cnt_m[2][8];
    bit stk_m[2][8];
    bit evt_m[2][8];
    bit past_m[2][8];
    bit pv_m[2];
    bit any_m[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pv_m[d] = 1'b0;
            any_m[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_m[d][i] = 0;
                stk_m[d][i] = 1'b0;
                evt_m[d][i] = 1'b0;
                past_m[d][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            any_m[d] = 1'b0;
            for (int i = 0; i < w[d]; i++) begin
                bit s, r, f, h;
                logic [1:0] m;
                s = sig[i];
                m = mode[2*i +: 2];
                if (pv_m[d]) begin
                    r = s && !past_m[d][i];
                    f = !s && past_m[d][i];
                end else begin
                    r = fse[d] && s;
                    f = fse[d] && !s;
                end
                case (m)
                    2'b00:   h = r;
                    2'b01:   h = f;
                    2'b10:   h = r || f;
                    default: h = 1'b0;
                endcase
                h = h && en;
                evt_m[d][i] = h;
                any_m[d] = any_m[d] || h;
                if (clr) begin
                    cnt_m[d][i] = 0;
                    stk_m[d][i] = 1'b0;
                end else if (h) begin
                    stk_m[d][i] = 1'b1;
                    if (cnt_m[d][i] < cmax[d]) cnt_m[d][i] = cnt_m[d][i] + 1;
                end
                past_m[d][i] = s;
            end
            pv_m[d] = 1'b1;
        end
    endtask

    function automatic logic [31:0] vec(input int d, input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < w[d]; i++)
            v[i] = (k == 0) ? evt_m[d][i] : (k == 1) ? stk_m[d][i] : (cnt_m[d][i] == cmax[d]);
        return v;
    endfunction

    function automatic logic [31:0] cnt_exp(input int d);
        return (int'(sel) < w[d]) ? 32'(cnt_m[d][sel]) : 32'd0;
    endfunction

    task automatic check_all();
        chk("evt_a",    32'(evt_a),    vec(0, 0));
        chk("sticky_a", 32'(sticky_a), vec(0, 1));
        chk("sat_a",    32'(sat_a),    vec(0, 2));
        chk("any_a",    32'(any_a),    32'(any_m[0]));
        chk("cnt_a",    32'(cnt_a),    cnt_exp(0));
        chk("evt_b",    32'(evt_b),    vec(1, 0));
        chk("sticky_b", 32'(sticky_b), vec(1, 1));
        chk("sat_b",    32'(sat_b),    vec(1, 2));
        chk("any_b",    32'(any_b),    32'(any_m[1]));
        chk("cnt_b",    32'(cnt_b),    cnt_exp(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        sel = 3'($urandom_range(0, 7));
        #1;
        check_all();
    endtask

    initial begin
        int exp_b[4] = '{2, 1, 3, 0};
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        en = 1'b1;
        mode = '0;
        sig = 8'h01;
        step();
        foreach (exp_b[k]) begin
            sig[0] = (k == 2);
            step();
        end
        sel = 3'd0;
        #1;
        chk("tp1_cnt0", 32'(cnt_a), 32'd2);
        chk("tp1_sticky0", 32'(sticky_a[0]), 32'd1);
        mode = 16'hFFE4;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sig = (k % 2 == 1) ? 8'h0F : 8'h00;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            sel = 3'(k);
            #1;
            chk("modes_cnt_b", 32'(cnt_b), 32'(exp_b[k]));
        end
        mode = '0;
        sig = '0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            sig[0] = 1'b1;
            step();
            sel = 3'd0;
            #1;
            chk("sat_cnt", 32'(cnt_a), 32'((n < 3) ? n : 3));
            chk("sat_flag", 32'(sat_a[0]), 32'(n >= 3));
            chk("sat_evt", 32'(evt_a[0]), 32'd1);
            sig[0] = 1'b0;
            step();
        end
        sig[1] = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        sel = 3'd1;
        #1;
        chk("clr_evt1", 32'(evt_a[1]), 32'd1);
        chk("clr_sticky1", 32'(sticky_a[1]), 32'd0);
        chk("clr_cnt1", 32'(cnt_a), 32'd0);
        sig[1] = 1'b0;
        step();
        sig[1] = 1'b1;
        step();
        sel = 3'd1;
        #1;
        chk("clr_next_cnt1", 32'(cnt_a), 32'd1);
        sig = '0;
        step();
        en = 1'b0;
        sig[0] = 1'b1;
        step();
        chk("en_off_evt0", 32'(evt_a[0]), 32'd0);
        en = 1'b1;
        step();
        chk("en_back_evt0", 32'(evt_a[0]), 32'd0);
        for (int k = 0; k < 200; k++) begin
            sig  = 8'($urandom);
            mode = 16'($urandom);
            en   = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            step();
        end
        clr = 1'b0;
        en = 1'b1;
        mode = 16'hAAAA;
        sig = 8'h00;
        step();
        sig = 8'hFF;
        step();
        chk("pre_rst_sticky_a", 32'(sticky_a), 32'hFF);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_sticky_a", 32'(sticky_a), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        mode = '0;
        sig = 8'h01;
        step();
        chk("post_rst_evt_a0", 32'(evt_a[0]), 32'd1);
        chk("post_rst_evt_b0", 32'(evt_b[0]), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
